// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM state
// encodings and the slice width of the time-multiplexed adder.
package add_ctrl_defs;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fullhalfadder_4b.sv
// 4-bit ripple adder slice: one half-sum/carry stage per bit, carry-in at
// bit 0, carry-out from bit 3.
module fullhalfadder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    logic p;
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (p & c[i]);
  end

  assign carry = c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built from one 4-bit slice, stepping one nibble per clock
// LSB-first with a registered carry; start/ready/done handshake.
module nibble_serial_add_ctrl
  import add_ctrl_defs::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int                IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx;
  logic                carry_reg;
  logic [W-1:0]        a_reg, b_reg, partial, partial_ins;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_carry;
  logic                accept, step, finish;

  assign nib_a = a_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_reg[idx*NIBBLE_W +: NIBBLE_W];

  fullhalfadder_4b u_slice (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_reg),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  // Partial sum with the current nibble already inserted, so the final
  // transfer to result includes the slice computed on the last edge.
  always_comb begin
    partial_ins = partial;
    partial_ins[idx*NIBBLE_W +: NIBBLE_W] = nib_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort wins over completion of the last nibble
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          step = 1'b1;
          if (idx == LAST_IDX) begin
            finish     = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      partial   <= '0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        a_reg     <= op_a;
        b_reg     <= op_b;
        carry_reg <= cin;
        partial   <= '0;
        idx       <= '0;
      end
      if (step) begin
        partial   <= partial_ins;
        carry_reg <= nib_carry;
        if (!finish) idx <= idx + IDX_W'(1);
      end
      if (finish) begin
        result   <= partial_ins;
        cout     <= nib_carry;
        overflow <= (a_reg[W-1] == b_reg[W-1]) && (nib_sum[NIBBLE_W-1] != a_reg[W-1]);
      end
    end
  end

  assign ready = (state == ST_IDLE);
  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4): vector table,
// abort, asynchronous reset and held-start sequences.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, abort, cin;
  logic [W-1:0] op_a, op_b;
  logic         ready, busy, done, cout, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [W-1:0] exp_res,
                                    input logic exp_c, input logic exp_o);
    check({tag, " ready"},    64'(ready),    64'd1);
    check({tag, " busy"},     64'(busy),     64'd0);
    check({tag, " done"},     64'(done),     64'd0);
    check({tag, " result"},   64'(result),   64'(exp_res));
    check({tag, " cout"},     64'(cout),     64'(exp_c));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_o));
  endtask

  // One full transaction; operands are scrambled right after acceptance.
  task automatic run_add(input string tag, input vec_t v);
    int cyc;
    bit got;
    @(negedge clk);
    op_a = v.a; op_b = v.b; cin = v.c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = ~v.a; op_b = ~v.b; cin = ~v.c;
    @(negedge clk);
    check({tag, " busy after accept"}, 64'(busy), 64'd1);
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) got = 1;
    end
    check({tag, " done latency"}, 64'(cyc), 64'(NIBBLES));
    check({tag, " result"},   64'(result),   64'(v.exp_sum));
    check({tag, " cout"},     64'(cout),     64'(v.exp_cout));
    check({tag, " overflow"}, 64'(overflow), 64'(v.exp_ovf));
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(done),  64'd0);
    check({tag, " ready after"},    64'(ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; cin = 1'b0;
    op_a = '0; op_b = '0;
    #1;
    check_idle_outputs("reset state", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_add($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset while idle with a non-zero result held.
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_idle_outputs("async reset idle", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_add("pre-abort", vecs[0]);

    // Abort at idx=2: no done pulse, result keeps 5555.
    @(negedge clk);
    op_a = 16'h0F0F; op_b = 16'h0101; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort", 16'h5555, 1'b0, 1'b0);
    begin
      bit seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      check("abort no done", 64'(seen), 64'd0);
    end
    run_add("post-abort", vecs[6]);

    // Reset mid-RUN: outputs clear at once and no done follows.
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h4321; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_idle_outputs("async reset run", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    begin
      bit seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      check("reset run no done", 64'(seen), 64'd0);
    end

    // start held high, operands changing every cycle: accepts at j=0,6,12.
    begin
      logic [W-1:0] a_hist[18], b_hist[18];
      logic         c_hist[18];
      for (int j = 0; j < 18; j++) begin
        a_hist[j] = 16'(j * 16'h1357 + 16'h0123);
        b_hist[j] = 16'(j * 16'h2468 + 16'h7F00);
        c_hist[j] = 1'(j & 1);
      end
      @(negedge clk);
      start = 1'b1;
      for (int j = 0; j < 18; j++) begin
        op_a = a_hist[j]; op_b = b_hist[j]; cin = c_hist[j];
        @(posedge clk);
        @(negedge clk);
        check($sformatf("held start done j%0d", j), 64'(done), 64'((j % 6) == 4));
        if ((j % 6) == 4) begin
          logic [W:0]   s;
          logic [W-1:0] ea, eb;
          ea = a_hist[j-4]; eb = b_hist[j-4];
          s  = {1'b0, ea} + {1'b0, eb} + (W+1)'(c_hist[j-4]);
          check($sformatf("held start result j%0d", j), 64'(result), 64'(s[W-1:0]));
          check($sformatf("held start cout j%0d", j),   64'(cout),   64'(s[W]));
          check($sformatf("held start ovf j%0d", j),    64'(overflow),
                64'((ea[W-1] == eb[W-1]) && (s[W-1] != ea[W-1])));
        end
      end
      start = 1'b0;
    end

    repeat (2) @(negedge clk);
    check("final ready", 64'(ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
